exe_fwd_stage: RTL

EXE_FWD_STAGE -- requirements
Module: exe_fwd_stage

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/exe_fwd_stage_if.sv | 73 +++++++
 rtl/operand_mux.sv | 30 +++
 rtl/exe_fwd_stage.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline definitions used by the execute-stage forwarding logic:
//   - forwarding select encodings (SEL_REG, SEL_EXE, SEL_WB)
//   - ALU command width (EXE_CMD_W)
//   - default register-index width (REG_W_DEFAULT)
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int EXE_CMD_W     = 4;
    localparam int REG_W_DEFAULT = 4;

    typedef logic [1:0] fwd_sel_t;

    // Code 2'b11 is unused by the forwarding unit and also selects the register value.
    localparam fwd_sel_t SEL_REG = 2'b00;
    localparam fwd_sel_t SEL_EXE = 2'b01;
    localparam fwd_sel_t SEL_WB  = 2'b10;

endpackage

// File: rtl/exe_fwd_stage_if.sv
// -----------------------------------------------------------------------------
// exe_fwd_stage_if
// Bundle of the decode-side inputs and execute-side outputs of exe_fwd_stage.
//   master : drives freeze/flush, id_* decode fields, forwarding selects/values;
//            observes ex_* fields, operands, hazard_stall and stall_cnt.
//   slave  : the execute stage itself (mirror directions).
// -----------------------------------------------------------------------------
interface exe_fwd_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = pipeline_pkg::REG_W_DEFAULT,
    parameter int CNT_W  = 16
);
    // Pipeline control
    logic                                freeze;
    logic                                flush;

    // Decode stage
    logic                                id_valid;
    logic                                id_wb_en;
    logic                                id_mem_r_en;
    logic                                id_mem_w_en;
    logic                                id_two_src;
    logic [pipeline_pkg::EXE_CMD_W-1:0]  id_exe_cmd;
    logic [REG_W-1:0]                    id_src1;
    logic [REG_W-1:0]                    id_src2;
    logic [REG_W-1:0]                    id_dest;
    logic [DATA_W-1:0]                   id_val_rn;
    logic [DATA_W-1:0]                   id_val_rm;
    logic [DATA_W-1:0]                   id_pc;

    // Forwarding unit
    pipeline_pkg::fwd_sel_t              sel_src1;
    pipeline_pkg::fwd_sel_t              sel_src2;
    logic [DATA_W-1:0]                   fwd_exe_val;
    logic [DATA_W-1:0]                   fwd_wb_val;

    // Execute stage
    logic                                ex_valid;
    logic                                ex_wb_en;
    logic                                ex_mem_r_en;
    logic                                ex_mem_w_en;
    logic [pipeline_pkg::EXE_CMD_W-1:0]  ex_exe_cmd;
    logic [REG_W-1:0]                    ex_src1;
    logic [REG_W-1:0]                    ex_src2;
    logic [REG_W-1:0]                    ex_dest;
    logic [DATA_W-1:0]                   ex_pc;
    logic [DATA_W-1:0]                   ex_op_a;
    logic [DATA_W-1:0]                   ex_op_b;
    logic [DATA_W-1:0]                   ex_store_val;
    logic                                hazard_stall;
    logic [CNT_W-1:0]                    stall_cnt;

    modport master (
        output freeze, flush,
        output id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_two_src,
        output id_exe_cmd, id_src1, id_src2, id_dest, id_val_rn, id_val_rm, id_pc,
        output sel_src1, sel_src2, fwd_exe_val, fwd_wb_val,
        input  ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en,
        input  ex_exe_cmd, ex_src1, ex_src2, ex_dest, ex_pc,
        input  ex_op_a, ex_op_b, ex_store_val, hazard_stall, stall_cnt
    );

    modport slave (
        input  freeze, flush,
        input  id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_two_src,
        input  id_exe_cmd, id_src1, id_src2, id_dest, id_val_rn, id_val_rm, id_pc,
        input  sel_src1, sel_src2, fwd_exe_val, fwd_wb_val,
        output ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en,
        output ex_exe_cmd, ex_src1, ex_src2, ex_dest, ex_pc,
        output ex_op_a, ex_op_b, ex_store_val, hazard_stall, stall_cnt
    );

endinterface

// File: rtl/operand_mux.sv
// -----------------------------------------------------------------------------
// operand_mux
// Three-input forwarding multiplexer for one ALU operand.
//   sel     in  2       forwarding select (00/11 register, 01 EXE/MEM, 10 WB)
//   reg_val in  DATA_W  value read from the register file in decode
//   exe_val in  DATA_W  result forwarded from EXE/MEM
//   wb_val  in  DATA_W  result forwarded from write-back
//   y       out DATA_W  selected operand
// -----------------------------------------------------------------------------
module operand_mux #(
    parameter int DATA_W = 32
) (
    input  pipeline_pkg::fwd_sel_t sel,
    input  logic [DATA_W-1:0]      reg_val,
    input  logic [DATA_W-1:0]      exe_val,
    input  logic [DATA_W-1:0]      wb_val,
    output logic [DATA_W-1:0]      y
);
    import pipeline_pkg::*;

    always_comb begin
        y = reg_val;
        case (sel)
            SEL_EXE: y = exe_val;
            SEL_WB:  y = wb_val;
            default: y = reg_val;
        endcase
    end

endmodule

// File: rtl/exe_fwd_stage.sv
// -----------------------------------------------------------------------------
// exe_fwd_stage
// ID/EX pipeline register with load-use hazard detection, bubble counting and
// operand forwarding muxes.
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous active-high reset
//   bus  slave   decode inputs, forwarding inputs, execute-stage outputs
// Register update priority: rst > flush > freeze > load-use bubble > load.
// A freeze (memory wait) holds the whole stage, so a pending load-use hazard
// inserts no bubble while frozen; flush always wins and is never counted.
// -----------------------------------------------------------------------------
module exe_fwd_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = pipeline_pkg::REG_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst,
    exe_fwd_stage_if.slave bus
);
    import pipeline_pkg::*;

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic [EXE_CMD_W-1:0] exe_cmd;
        logic [REG_W-1:0]     src1;
        logic [REG_W-1:0]     src2;
        logic [REG_W-1:0]     dest;
        logic [DATA_W-1:0]    val_rn;
        logic [DATA_W-1:0]    val_rm;
        logic [DATA_W-1:0]    pc;
    } idex_t;

    idex_t             idex_q, idex_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              src_match;
    logic              hazard;
    logic              bubble;
    logic [DATA_W-1:0] op_a, op_b;

    // Load-use: the instruction in EX is a load whose destination is read by
    // the instruction in ID. src2 only matters when ID actually reads it.
    always_comb begin
        src_match = (bus.id_src1 == idex_q.dest) ||
                    (bus.id_two_src && (bus.id_src2 == idex_q.dest));
        hazard    = !rst && bus.id_valid && idex_q.valid && idex_q.mem_r_en && src_match;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
        idex_d = idex_q;
        bubble = 1'b0;
        if (bus.flush) begin
            idex_d = '0;
        end else if (bus.freeze) begin
            idex_d = idex_q;
        end else if (hazard) begin
            // Upstream holds on hazard_stall; the same ID instruction retries next cycle.
            idex_d = '0;
            bubble = 1'b1;
        end else begin
            idex_d.valid    = bus.id_valid;
            idex_d.wb_en    = bus.id_wb_en;
            idex_d.mem_r_en = bus.id_mem_r_en;
            idex_d.mem_w_en = bus.id_mem_w_en;
            idex_d.exe_cmd  = bus.id_exe_cmd;
            idex_d.src1     = bus.id_src1;
            idex_d.src2     = bus.id_src2;
            idex_d.dest     = bus.id_dest;
            idex_d.val_rn   = bus.id_val_rn;
            idex_d.val_rm   = bus.id_val_rm;
            idex_d.pc       = bus.id_pc;
        end
    end

    // Saturating bubble counter: sticks at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    operand_mux #(.DATA_W(DATA_W)) u_mux_a (
        .sel     (bus.sel_src1),
        .reg_val (idex_q.val_rn),
        .exe_val (bus.fwd_exe_val),
        .wb_val  (bus.fwd_wb_val),
        .y       (op_a)
    );

    operand_mux #(.DATA_W(DATA_W)) u_mux_b (
        .sel     (bus.sel_src2),
        .reg_val (idex_q.val_rm),
        .exe_val (bus.fwd_exe_val),
        .wb_val  (bus.fwd_wb_val),
        .y       (op_b)
    );

    assign bus.ex_valid     = idex_q.valid;
    assign bus.ex_wb_en     = idex_q.wb_en;
    assign bus.ex_mem_r_en  = idex_q.mem_r_en;
    assign bus.ex_mem_w_en  = idex_q.mem_w_en;
    assign bus.ex_exe_cmd   = idex_q.exe_cmd;
    assign bus.ex_src1      = idex_q.src1;
    assign bus.ex_src2      = idex_q.src2;
    assign bus.ex_dest      = idex_q.dest;
    assign bus.ex_pc        = idex_q.pc;
    assign bus.ex_op_a      = op_a;
    assign bus.ex_op_b      = op_b;
    assign bus.ex_store_val = op_b;
    assign bus.hazard_stall = hazard;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule
